// File: rtl/ofm_write_addr_controller_pkg.sv
// Shared definitions for the OFM write/read address controllers:
// tile geometry, RAM address width, FSM state encodings and the latched
// layer configuration payload.
package ofm_write_addr_controller_pkg;

  localparam int unsigned SYSTOLIC_SIZE = 16;
  localparam int unsigned OFM_RAM_SIZE  = 2378675;
  localparam int unsigned AW            = $clog2(OFM_RAM_SIZE);
  localparam int unsigned SIZE_W        = 9;   // ofm height/width
  localparam int unsigned CH_W          = 11;  // output channel count
  localparam int unsigned CNT_W         = 5;   // per-tile pixel/filter count (0..16)

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_WRITE       = 2'd1;
  localparam logic [1:0] ST_NEXT_TILING = 2'd2;

  typedef struct packed {
    logic [AW-1:0]     layer_base;
    logic [SIZE_W-1:0] ofm_size;
    logic [CH_W-1:0]   ofm_channel;
  } layer_cfg_t;

  // Clamp a remaining count to one tile's worth.
  function automatic logic [CNT_W-1:0] min_tile(input logic [CH_W-1:0] remain);
    if (remain >= CH_W'(SYSTOLIC_SIZE)) return CNT_W'(SYSTOLIC_SIZE);
    return CNT_W'(remain);
  endfunction

endpackage

// File: rtl/ofm_write_addr_controller_tile_position.sv
// ofm_tile_position: layer configuration latch plus the tile walk counters
// (row inside a column strip, column strip, channel group).
// Ports:
//   load             - capture layer config, zero the tile position
//   advance          - step to the next tile (one cycle, end of tile)
//   start_write_addr, ofm_size, ofm_channel - layer config inputs
//   plane            - ofm_size*ofm_size of the latched layer
//   tile_base_c      - first address of the current tile
//   write_ofm_size_c - valid pixels per row segment of the current tile
//   num_filter_c     - valid filters of the current tile
//   last_tile_c      - current tile is the last one of the layer
import ofm_write_addr_controller_pkg::*;

module ofm_tile_position (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [AW-1:0]     start_write_addr,
  input  logic [SIZE_W-1:0] ofm_size,
  input  logic [CH_W-1:0]   ofm_channel,
  output logic [AW-1:0]     plane,
  output logic [AW-1:0]     tile_base_c,
  output logic [CNT_W-1:0]  write_ofm_size_c,
  output logic [CNT_W-1:0]  num_filter_c,
  output logic              last_tile_c
);

  layer_cfg_t        cfg;
  logic [SIZE_W-1:0] row;
  logic [SIZE_W-1:0] col_base;
  logic [CH_W-1:0]   ch_base;

  logic [SIZE_W-1:0] col_rem;
  logic [CH_W-1:0]   ch_rem;
  logic              last_row;
  logic              last_strip;
  logic              last_group;

  // Tile sizes, wrap conditions and tile base address.
  always_comb begin
    col_rem          = cfg.ofm_size - col_base;
    ch_rem           = cfg.ofm_channel - ch_base;
    write_ofm_size_c = min_tile(CH_W'(col_rem));
    num_filter_c     = min_tile(ch_rem);
    last_row         = (row == cfg.ofm_size - SIZE_W'(1));
    last_strip       = ((col_base + SIZE_W'(write_ofm_size_c)) == cfg.ofm_size);
    last_group       = ((ch_base + CH_W'(num_filter_c)) == cfg.ofm_channel);
    last_tile_c      = last_row && last_strip && last_group;
    tile_base_c      = cfg.layer_base + AW'(ch_base) * plane
                     + AW'(row) * AW'(cfg.ofm_size) + AW'(col_base);
  end

  // Config latch and row -> strip -> channel-group walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg      <= '0;
      plane    <= '0;
      row      <= '0;
      col_base <= '0;
      ch_base  <= '0;
    end else if (load) begin
      cfg.layer_base  <= start_write_addr;
      cfg.ofm_size    <= ofm_size;
      cfg.ofm_channel <= ofm_channel;
      plane           <= AW'(ofm_size) * AW'(ofm_size);
      row             <= '0;
      col_base        <= '0;
      ch_base         <= '0;
    end else if (advance) begin
      if (!last_row) begin
        row <= row + SIZE_W'(1);
      end else begin
        row <= '0;
        if (!last_strip) begin
          col_base <= col_base + SIZE_W'(SYSTOLIC_SIZE);
        end else begin
          col_base <= '0;
          // Last group wraps back to the layer start.
          ch_base  <= last_group ? '0 : ch_base + CH_W'(SYSTOLIC_SIZE);
        end
      end
    end
  end

endmodule

// File: rtl/ofm_write_addr_controller.sv
// OFM RAM write address generator. Each write pulse turns the current tile
// into a filter-major stream of one address per cycle in channel-planar
// layout, then steps the tile position and reports layer completion.
// Ports:
//   start / start_write_addr / ofm_size / ofm_channel - layer setup (IDLE only)
//   write          - tile ready from the systolic output buffer (IDLE only)
//   stall          - hold address, suppress write_en for a cycle
//   ofm_addr, write_en             - RAM write port
//   write_ofm_size, num_filter     - geometry of the tile being written
//   busy           - tile in progress (WRITE or NEXT_TILING)
//   done           - last tile of the layer finished (NEXT_TILING cycle)
import ofm_write_addr_controller_pkg::*;

module ofm_write_addr_controller (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     start_write_addr,
  input  logic              write,
  input  logic              stall,
  input  logic [SIZE_W-1:0] ofm_size,
  input  logic [CH_W-1:0]   ofm_channel,
  output logic [AW-1:0]     ofm_addr,
  output logic              write_en,
  output logic [CNT_W-1:0]  write_ofm_size,
  output logic [CNT_W-1:0]  num_filter,
  output logic              busy,
  output logic              done
);

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    ofm_addr_nxt;
  logic [AW-1:0]    row_addr, row_addr_nxt;  // address of pixel 0 of current filter
  logic [CNT_W-1:0] f_cnt, f_nxt;
  logic [CNT_W-1:0] p_cnt, p_nxt;
  logic [CNT_W-1:0] wos_nxt, nf_nxt;
  logic             write_en_nxt, busy_nxt, done_nxt;

  logic             load_c, advance_c, last_word_c, last_pix_c;
  logic [AW-1:0]    plane, tile_base_c;
  logic [CNT_W-1:0] write_ofm_size_c, num_filter_c;
  logic             last_tile_c;

  assign load_c      = start && (state == ST_IDLE);
  assign advance_c   = (state == ST_NEXT_TILING);
  assign last_pix_c  = (p_cnt == write_ofm_size - CNT_W'(1));
  assign last_word_c = last_pix_c && (f_cnt == num_filter - CNT_W'(1));

  ofm_tile_position u_tile_position (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (load_c),
    .advance          (advance_c),
    .start_write_addr (start_write_addr),
    .ofm_size         (ofm_size),
    .ofm_channel      (ofm_channel),
    .plane            (plane),
    .tile_base_c      (tile_base_c),
    .write_ofm_size_c (write_ofm_size_c),
    .num_filter_c     (num_filter_c),
    .last_tile_c      (last_tile_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ofm_addr       <= '0;
      row_addr       <= '0;
      write_en       <= 1'b0;
      f_cnt          <= '0;
      p_cnt          <= '0;
      write_ofm_size <= '0;
      num_filter     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      ofm_addr       <= ofm_addr_nxt;
      row_addr       <= row_addr_nxt;
      write_en       <= write_en_nxt;
      f_cnt          <= f_nxt;
      p_cnt          <= p_nxt;
      write_ofm_size <= wos_nxt;
      num_filter     <= nf_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
    end
  end

  // Next state and in-tile address stepping.
  always_comb begin
    state_nxt    = state;
    ofm_addr_nxt = ofm_addr;
    row_addr_nxt = row_addr;
    write_en_nxt = write_en;
    f_nxt        = f_cnt;
    p_nxt        = p_cnt;
    wos_nxt      = write_ofm_size;
    nf_nxt       = num_filter;
    busy_nxt     = busy;
    done_nxt     = done;

    case (state)
      ST_IDLE: begin
        write_en_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        // start takes priority; the tile geometry is frozen on entry.
        if (!start && write) begin
          state_nxt    = ST_WRITE;
          ofm_addr_nxt = tile_base_c;
          row_addr_nxt = tile_base_c;
          wos_nxt      = write_ofm_size_c;
          nf_nxt       = num_filter_c;
          f_nxt        = '0;
          p_nxt        = '0;
          write_en_nxt = 1'b1;
          busy_nxt     = 1'b1;
        end
      end

      ST_WRITE: begin
        if (write_en) begin
          if (last_word_c) begin
            state_nxt    = ST_NEXT_TILING;
            write_en_nxt = 1'b0;
            done_nxt     = last_tile_c;
          end else begin
            write_en_nxt = !stall;
            if (last_pix_c) begin
              // Jump straight to the next filter plane, no bubble.
              p_nxt        = '0;
              f_nxt        = f_cnt + CNT_W'(1);
              row_addr_nxt = row_addr + plane;
              ofm_addr_nxt = row_addr + plane;
            end else begin
              p_nxt        = p_cnt + CNT_W'(1);
              ofm_addr_nxt = ofm_addr + AW'(1);
            end
          end
        end else begin
          // Stalled cycle: address already points at the pending word.
          write_en_nxt = !stall;
        end
      end

      ST_NEXT_TILING: begin
        state_nxt    = ST_IDLE;
        write_en_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
      end

      default: begin
        state_nxt    = ST_IDLE;
        write_en_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ofm_write_addr_controller.sv
// Self-checking bench for ofm_write_addr_controller. The reference model
// derives each tile's position directly from its index in the layer walk.
import ofm_write_addr_controller_pkg::*;

module tb_ofm_write_addr_controller;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     start_write_addr;
  logic              write;
  logic              stall;
  logic [SIZE_W-1:0] ofm_size;
  logic [CH_W-1:0]   ofm_channel;
  logic [AW-1:0]     ofm_addr;
  logic              write_en;
  logic [CNT_W-1:0]  write_ofm_size;
  logic [CNT_W-1:0]  num_filter;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  int m_size, m_ch, m_base;

  ofm_write_addr_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .start_write_addr (start_write_addr),
    .write            (write),
    .stall            (stall),
    .ofm_size         (ofm_size),
    .ofm_channel      (ofm_channel),
    .ofm_addr         (ofm_addr),
    .write_en         (write_en),
    .write_ofm_size   (write_ofm_size),
    .num_filter       (num_filter),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int sz, input int ch, input int base);
    start            = 1'b1;
    ofm_size         = SIZE_W'(sz);
    ofm_channel      = CH_W'(ch);
    start_write_addr = AW'(base);
    m_size = sz; m_ch = ch; m_base = base;
    tick();
    start = 1'b0;
  endtask

  function automatic int layer_tiles();
    return m_size * ((m_size + 15) / 16) * ((m_ch + 15) / 16);
  endfunction

  // mode: 0 plain, 1 random stalls, 2 three-cycle stall after word 2,
  //       3 write+start pulse while the tile is being written
  task automatic run_tile(input int k, input int mode);
    int strips, kk, grp, rem, row, colb, chb, wos, nf, n, plane, tb;
    int idx, gap, egap, cyc, trip, budget;
    bit s, exp_done;
    strips   = (m_size + 15) / 16;
    kk       = k % layer_tiles();
    exp_done = (kk == layer_tiles() - 1);
    grp      = kk / (m_size * strips);
    rem      = kk % (m_size * strips);
    colb     = (rem / m_size) * 16;
    row      = rem % m_size;
    chb      = grp * 16;
    wos      = (m_size - colb > 16) ? 16 : m_size - colb;
    nf       = (m_ch - chb > 16) ? 16 : m_ch - chb;
    n        = wos * nf;
    plane    = m_size * m_size;
    tb       = m_base + chb * plane + row * m_size + colb;
    budget   = 4 * n + 40;

    write = 1'b1;
    tick();
    write = 1'b0;
    check("first_addr", 32'(ofm_addr), 32'(tb));
    check("first_we", 32'(write_en), 32'd1);
    check("write_ofm_size", 32'(write_ofm_size), 32'(wos));
    check("num_filter", 32'(num_filter), 32'(nf));
    check("busy_tile", 32'(busy), 32'd1);

    idx = 0; gap = 0; egap = 0; cyc = 0; trip = 0;
    while (idx < n && cyc < budget) begin
      if (write_en) begin
        check("addr", 32'(ofm_addr), 32'(tb + (idx / wos) * plane + idx % wos));
        idx++;
      end else begin
        gap++;
        check("held_addr", 32'(ofm_addr), 32'(tb + (idx / wos) * plane + idx % wos));
      end
      s = 1'b0;
      write = 1'b0;
      start = 1'b0;
      if (idx < n) begin
        case (mode)
          1: s = ($urandom_range(0, 3) == 0);
          2: if (idx == 2 && trip < 3) begin s = 1'b1; trip++; end
          3: if (cyc == 1) begin
               write = 1'b1;
               start = 1'b1;
               start_write_addr = AW'(12345);
             end
          default: s = 1'b0;
        endcase
      end
      stall = s;
      if (s) egap++;
      tick();
      cyc++;
    end
    stall = 1'b0; write = 1'b0; start = 1'b0;
    check("words_in_budget", 32'(idx), 32'(n));
    check("stall_gap", 32'(gap), 32'(egap));
    check("tile_cycles", 32'(cyc), 32'(n + egap));
    if (mode == 2) check("triple_stall", 32'(gap), 32'd3);
    check("nt_we", 32'(write_en), 32'd0);
    check("nt_busy", 32'(busy), 32'd1);
    check("nt_done", 32'(done), 32'(exp_done));
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    int sz, ch, base, nt;
    rst_n = 1'b0; start = 1'b0; write = 1'b0; stall = 1'b0;
    start_write_addr = '0; ofm_size = '0; ofm_channel = '0;
    tick();
    tick();
    check("rst_addr", 32'(ofm_addr), 32'd0);
    check("rst_we", 32'(write_en), 32'd0);
    check("rst_wos", 32'(write_ofm_size), 32'd0);
    check("rst_nf", 32'(num_filter), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 4x4 map, 2 channels, base 100: four tiles, then wrap to the start.
    do_start(4, 2, 100);
    for (int k = 0; k <= 4; k++) run_tile(k, 0);
    run_tile(1, 2);

    // start together with write: start wins, no tile begins.
    start = 1'b1; write = 1'b1;
    ofm_size = 9'd4; ofm_channel = 11'd2; start_write_addr = AW'(500);
    m_size = 4; m_ch = 2; m_base = 500;
    tick();
    start = 1'b0; write = 1'b0;
    check("sw_we0", 32'(write_en), 32'd0);
    check("sw_busy0", 32'(busy), 32'd0);
    tick();
    check("sw_we1", 32'(write_en), 32'd0);
    start_write_addr = AW'(500);
    run_tile(0, 3);
    run_tile(1, 0);

    // 20x20 map, one channel: two column strips, 40 tiles.
    do_start(20, 1, 0);
    for (int k = 0; k < 40; k++) run_tile(k, 0);

    // 2x2 map, 40 channels: groups of 16, 16, 8.
    do_start(2, 40, 7000);
    for (int k = 0; k < 6; k++) run_tile(k, 0);

    // Reset in the middle of a tile.
    write = 1'b1;
    tick();
    write = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(ofm_addr), 32'd0);
    check("mid_rst_we", 32'(write_en), 32'd0);
    check("mid_rst_wos", 32'(write_ofm_size), 32'd0);
    check("mid_rst_nf", 32'(num_filter), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2, 40, 7000);
    run_tile(0, 0);

    // Random small layers walked end to end with random stalls.
    for (int r = 0; r < 4; r++) begin
      sz   = $urandom_range(1, 6);
      ch   = $urandom_range(1, 36);
      base = $urandom_range(0, 200000);
      do_start(sz, ch, base);
      nt = layer_tiles();
      for (int k = 0; k <= nt; k++) run_tile(k, 1);
    end

    // Random wider layers, first few tiles only.
    for (int r = 0; r < 2; r++) begin
      sz   = $urandom_range(17, 40);
      ch   = $urandom_range(1, 20);
      base = $urandom_range(0, 100000);
      do_start(sz, ch, base);
      for (int k = 0; k < 6; k++) run_tile(k, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
